// File: rtl/ysyx_23060332_sram_ctrl.sv
// Word-addressed on-chip data memory with independent read/write valid-ready channels.
// State | meaning: S_IDLE | request accepted | S_WAIT | latency countdown | S_RESP | response held until accepted.
module ysyx_23060332_sram_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int RC_W  = $clog2(RD_LATENCY + 1);
  localparam int WC_W  = $clog2(WR_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

  state_t                rd_state;
  logic [RC_W-1:0]       rd_cnt;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_ok;

  state_t                wr_state;
  logic [WC_W-1:0]       wr_cnt;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;

  logic ar_in_range;
  logic aw_in_range;
  logic wr_commit;

  // Anything above the word-index field must be zero for the access to hit the array.
  assign ar_in_range = (araddr >> (OFF + DEPTH_LOG2)) == '0;
  assign aw_in_range = (awaddr >> (OFF + DEPTH_LOG2)) == '0;

  assign arready = (rd_state == S_IDLE) && !rst;
  assign awready = (wr_state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= S_IDLE;
      rd_cnt   <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= 2'b00;
    end else begin
      case (rd_state)
        S_IDLE: begin
          if (arvalid && arready) begin
            rd_idx   <= araddr[OFF +: DEPTH_LOG2];
            rd_ok    <= ar_in_range;
            rd_cnt   <= RC_W'(RD_LATENCY - 1);
            rd_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rd_cnt == '0) begin
            rdata    <= rd_ok ? mem[rd_idx] : '0;
            rresp    <= rd_ok ? 2'b00 : 2'b10;
            rvalid   <= 1'b1;
            rd_state <= S_RESP;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            rd_state <= S_IDLE;
          end
        end
        default: rd_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= S_IDLE;
      wr_cnt   <= '0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
    end else begin
      case (wr_state)
        S_IDLE: begin
          if (awvalid && awready) begin
            wr_idx   <= awaddr[OFF +: DEPTH_LOG2];
            wr_ok    <= aw_in_range;
            wr_data  <= wdata;
            wr_strb  <= wstrb;
            wr_cnt   <= WC_W'(WR_LATENCY - 1);
            wr_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wr_cnt == '0) begin
            bresp    <= wr_ok ? 2'b00 : 2'b10;
            bvalid   <= 1'b1;
            wr_state <= S_RESP;
          end else begin
            wr_cnt <= wr_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            wr_state <= S_IDLE;
          end
        end
        default: wr_state <= S_IDLE;
      endcase
    end
  end

  // Commit lands on the same edge bvalid rises; a same-edge read sees the old word.
  assign wr_commit = !rst && (wr_state == S_WAIT) && (wr_cnt == '0) && wr_ok;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_sram_ctrl.sv
// Bench for ysyx_23060332_sram_ctrl: unit 0 at default latency, unit 1 at RD=4/WR=3.
module tb_ysyx_23060332_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] awaddr  [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic [1:0]  bresp   [2];

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq [$];
  logic [1:0]  bq [$];
  logic [31:0] model [2][1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060332_sram_ctrl u0 (
    .clk(clk), .rst(rst),
    .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]),
    .awvalid(awvalid[0]), .awready(awready[0]), .awaddr(awaddr[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]),
    .bvalid(bvalid[0]), .bready(bready[0]), .bresp(bresp[0])
  );

  ysyx_23060332_sram_ctrl #(.RD_LATENCY(4), .WR_LATENCY(3)) u1 (
    .clk(clk), .rst(rst),
    .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]),
    .awvalid(awvalid[1]), .awready(awready[1]), .awaddr(awaddr[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]),
    .bvalid(bvalid[1]), .bready(bready[1]), .bresp(bresp[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int lat);
    int n;
    logic ok;
    ok = (a[31:12] == 20'h0);
    bq.push_back(ok ? 2'b00 : 2'b10);
    @(negedge clk);
    awaddr[u] = a; wdata[u] = d; wstrb[u] = s; awvalid[u] = 1'b1;
    n = 0;
    while (!awready[u] && n < 20) begin @(negedge clk); n++; end
    check_eq("awready", awready[u], 1);
    @(posedge clk); #1;
    awvalid[u] = 1'b0; awaddr[u] = 32'h0; wdata[u] = ~d; wstrb[u] = 4'hF;
    if (ok) model[u][a[11:2]] = merge(model[u][a[11:2]], d, s);
    n = 0;
    while (!bvalid[u] && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("wr_latency", n, lat);
    check_eq("bresp", bresp[u], bq.pop_front());
    bready[u] = 1'b1;
    @(posedge clk); #1;
    bready[u] = 1'b0;
    check_eq("bvalid_drop", bvalid[u], 0);
  endtask

  task automatic rd(input int u, input logic [31:0] a, input int lat, input int hold);
    int n;
    rexp_t e;
    logic ok;
    ok = (a[31:12] == 20'h0);
    e.d = ok ? model[u][a[11:2]] : 32'h0;
    e.r = ok ? 2'b00 : 2'b10;
    rq.push_back(e);
    @(negedge clk);
    araddr[u] = a; arvalid[u] = 1'b1;
    n = 0;
    while (!arready[u] && n < 20) begin @(negedge clk); n++; end
    check_eq("arready", arready[u], 1);
    @(posedge clk); #1;
    arvalid[u] = 1'b0; araddr[u] = ~a;
    n = 0;
    while (!rvalid[u] && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("rd_latency", n, lat);
    e = rq.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("rvalid_hold", rvalid[u], 1);
      check_eq("rdata_hold", rdata[u], e.d);
      check_eq("arready_hold", arready[u], 0);
    end
    check_eq("rdata", rdata[u], e.d);
    check_eq("rresp", rresp[u], e.r);
    rready[u] = 1'b1;
    @(posedge clk); #1;
    rready[u] = 1'b0;
    check_eq("rvalid_drop", rvalid[u], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      arvalid[u] = 0; rready[u] = 0; awvalid[u] = 0; bready[u] = 0;
      araddr[u] = 0; awaddr[u] = 0; wdata[u] = 0; wstrb[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_eq("rst_arready", arready[u], 0);
      check_eq("rst_awready", awready[u], 0);
      check_eq("rst_rvalid", rvalid[u], 0);
      check_eq("rst_bvalid", bvalid[u], 0);
      check_eq("rst_rdata", rdata[u], 0);
      check_eq("rst_rresp", rresp[u], 0);
      check_eq("rst_bresp", bresp[u], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check_eq("arready_post_rst", arready[u], 1);
      check_eq("awready_post_rst", awready[u], 1);
    end

    // basic write/read, partial strobes, ignored low address bits
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1);
    rd(0, 32'h10, 1, 0);
    wr(0, 32'h10, 32'h11223344, 4'h5, 1);
    rd(0, 32'h10, 1, 0);
    check_eq("merge_model", model[0][4], 32'hDE22BE44);
    rd(0, 32'h13, 1, 2);

    // long latency with read back-pressure, zero strobe
    wr(1, 32'h40, 32'hCAFEF00D, 4'hF, 3);
    rd(1, 32'h40, 4, 5);
    wr(1, 32'h40, 32'h0, 4'h0, 3);
    rd(1, 32'h40, 4, 0);
    wr(1, 32'h44, 32'h12345678, 4'hA, 3);

    // out of range
    wr(0, 32'h0, 32'h01234567, 4'hF, 1);
    wr(0, 32'h1000, 32'hFFFFFFFF, 4'hF, 1);
    rd(0, 32'h1000, 1, 0);
    rd(0, 32'h0, 1, 0);
    rd(1, 32'h1004, 4, 1);

    // same-edge read sample and write commit
    wr(0, 32'h20, 32'hAAAAAAAA, 4'hF, 1);
    fork
      wr(0, 32'h20, 32'h55555555, 4'hF, 1);
      rd(0, 32'h20, 1, 0);
    join
    rd(0, 32'h20, 1, 0);

    // reset while both channels of both units are waiting
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      araddr[u] = (u == 0) ? 32'h10 : 32'h40;
      awaddr[u] = (u == 0) ? 32'h10 : 32'h40;
      wdata[u] = 32'h0BADF00D; wstrb[u] = 4'hF;
      arvalid[u] = 1'b1; awvalid[u] = 1'b1;
    end
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin arvalid[u] = 0; awvalid[u] = 0; end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("arready_in_rst", arready[0], 0);
    check_eq("awready_in_rst", awready[1], 0);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check_eq("arready_after_rst", arready[u], 1);
      check_eq("awready_after_rst", awready[u], 1);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) if (rvalid[u] || bvalid[u]) seen++;
    end
    check_eq("no_resp_after_rst", seen, 0);
    rd(0, 32'h10, 1, 0);
    rd(1, 32'h40, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
